keypad_scan: RTL and testbench



---
 rtl/keypad_scan.sv | 153 +++++++++++++++
 tb/tb_keypad_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - debounced 4x4 matrix keypad scanner with valid/ack key handoff
module keypad_scan #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       orgclk,
  input  logic       reset,
  input  logic       hz512,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       key_ovr
);

  typedef enum logic [1:0] {RES_NONE = 2'd0, RES_KEY = 2'd1, RES_MULTI = 2'd2} res_t;
  typedef enum logic {IDLE = 1'b0, PRESSED = 1'b1} state_t;

  logic [3:0] row_m;
  logic [3:0] row_s;
  logic       hz512_d;
  logic       tick;
  logic [1:0] col_idx;
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;
  res_t       prev_res;
  logic [3:0] prev_code;
  logic [3:0] stable_cnt;
  state_t     state;

  logic [3:0] hit;
  logic [2:0] col_cnt;
  logic [1:0] row_first;
  logic [1:0] base_cnt;
  logic [3:0] base_code;
  logic [1:0] frame_cnt;
  logic [3:0] frame_code;
  res_t       res;
  logic [3:0] res_code;
  logic [3:0] next_stable;
  logic       frame_end;
  logic       debounced;
  logic       accept;
  logic       rel_done;

  assign tick = hz512 & ~hz512_d;
  assign col  = ~(4'b0001 << col_idx);

  // Frame accumulator only needs to distinguish 0, 1 and "more than one" keys.
  always_comb begin
    hit     = ~row_s;
    col_cnt = {2'b00, hit[0]} + {2'b00, hit[1]} + {2'b00, hit[2]} + {2'b00, hit[3]};
    if (hit[0])      row_first = 2'd0;
    else if (hit[1]) row_first = 2'd1;
    else if (hit[2]) row_first = 2'd2;
    else             row_first = 2'd3;

    base_cnt   = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
    base_code  = (col_idx == 2'd0) ? 4'd0 : acc_code;
    frame_cnt  = base_cnt;
    frame_code = base_code;
    if (col_cnt != 3'd0) begin
      if (base_cnt == 2'd0) begin
        frame_cnt  = (col_cnt == 3'd1) ? 2'd1 : 2'd2;
        frame_code = {col_idx, row_first};
      end else begin
        frame_cnt = 2'd2;
      end
    end

    case (frame_cnt)
      2'd0:    res = RES_NONE;
      2'd1:    res = RES_KEY;
      default: res = RES_MULTI;
    endcase
    // Code is zeroed for NONE/MULTI so those results compare equal frame to frame.
    res_code = (res == RES_KEY) ? frame_code : 4'd0;

    if (res == prev_res && res_code == prev_code)
      next_stable = (stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1;
    else
      next_stable = 4'd1;

    frame_end = tick && (col_idx == 2'd3);
    debounced = (next_stable == 4'(DEBOUNCE));
    accept    = frame_end && (state == IDLE) && (res == RES_KEY) && debounced;
    rel_done  = frame_end && (state == PRESSED) && (res == RES_NONE) && debounced;
  end

  always_ff @(posedge orgclk or posedge reset) begin
    if (reset) begin
      row_m      <= 4'hF;
      row_s      <= 4'hF;
      hz512_d    <= 1'b0;
      col_idx    <= 2'd0;
      acc_cnt    <= 2'd0;
      acc_code   <= 4'd0;
      prev_res   <= RES_NONE;
      prev_code  <= 4'd0;
      stable_cnt <= 4'd0;
    end else begin
      row_m   <= row;
      row_s   <= row_m;
      hz512_d <= hz512;
      if (tick) begin
        col_idx  <= col_idx + 2'd1;
        acc_cnt  <= frame_cnt;
        acc_code <= frame_code;
        if (col_idx == 2'd3) begin
          prev_res   <= res;
          prev_code  <= res_code;
          stable_cnt <= next_stable;
        end
      end
    end
  end

  always_ff @(posedge orgclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      key_ovr   <= 1'b0;
    end else begin
      if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        key_ovr   <= 1'b0;
      end
      case (state)
        IDLE: begin
          // An accept overrides a same-cycle ack; overrun only if the old key was unclaimed.
          if (accept) begin
            state     <= PRESSED;
            key_down  <= 1'b1;
            key_valid <= 1'b1;
            key_code  <= res_code;
            if (key_valid && !key_ack) key_ovr <= 1'b1;
          end
        end
        PRESSED: begin
          if (rel_done) begin
            state    <= IDLE;
            key_down <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - table-driven bench for keypad_scan with a keypad matrix model
module tb_keypad_scan;

  logic        orgclk = 1'b0;
  logic        reset;
  logic        hz512;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        key_down;
  logic        key_ovr;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  keypad_scan #(.DEBOUNCE(4)) dut (
    .orgclk    (orgclk),
    .reset     (reset),
    .hz512     (hz512),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_down  (key_down),
    .key_ovr   (key_ovr)
  );

  always #5 orgclk = ~orgclk;

  // Key {c,r} pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4 + r]) row[r] = 1'b0;
  end

  typedef struct {
    int          ticks;
    logic [15:0] keys;
    logic        ack;
    logic [3:0]  e_col;
    logic        e_valid;
    logic        e_down;
    logic        e_ovr;
    logic [3:0]  e_code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int t, input logic [15:0] k, input logic a, input logic [3:0] ec,
                     input logic ev, input logic ed, input logic eo, input logic [3:0] ecode);
    vec_t v;
    v.ticks = t; v.keys = k; v.ack = a; v.e_col = ec;
    v.e_valid = ev; v.e_down = ed; v.e_ovr = eo; v.e_code = ecode;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ec, input logic ev,
                         input logic ed, input logic eo, input logic [3:0] ecode);
    chk({tag, "_col"},   col,               ec);
    chk({tag, "_valid"}, {3'b000, key_valid}, {3'b000, ev});
    chk({tag, "_down"},  {3'b000, key_down},  {3'b000, ed});
    chk({tag, "_ovr"},   {3'b000, key_ovr},   {3'b000, eo});
    chk({tag, "_code"},  key_code,          ecode);
  endtask

  // One 64-cycle scan tick; rows settle through the synchronizer before hz512 rises.
  task automatic do_tick(input logic ack);
    repeat (4) @(negedge orgclk);
    hz512   = 1'b1;
    key_ack = ack;
    @(negedge orgclk);
    key_ack = 1'b0;
    repeat (31) @(negedge orgclk);
    hz512 = 1'b0;
    repeat (28) @(negedge orgclk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; hz512 = 1'b0; key_ack = 1'b0; keys = 16'h0;

    add(1,  16'h0000, 0, 4'b1101, 0, 0, 0, 4'h0);
    add(1,  16'h0000, 0, 4'b1011, 0, 0, 0, 4'h0);
    add(1,  16'h0000, 0, 4'b0111, 0, 0, 0, 4'h0);
    add(1,  16'h0000, 0, 4'b1110, 0, 0, 0, 4'h0);
    add(12, 16'h0200, 0, 4'b1110, 0, 0, 0, 4'h0);
    add(4,  16'h0200, 0, 4'b1110, 1, 1, 0, 4'h9);
    add(0,  16'h0200, 1, 4'b1110, 0, 1, 0, 4'h9);
    add(12, 16'h0000, 0, 4'b1110, 0, 1, 0, 4'h9);
    add(4,  16'h0000, 0, 4'b1110, 0, 0, 0, 4'h9);
    add(4,  16'h0020, 0, 4'b1110, 0, 0, 0, 4'h9);
    add(4,  16'h0000, 0, 4'b1110, 0, 0, 0, 4'h9);
    add(4,  16'h0020, 0, 4'b1110, 0, 0, 0, 4'h9);
    add(4,  16'h0000, 0, 4'b1110, 0, 0, 0, 4'h9);
    add(12, 16'h0020, 0, 4'b1110, 0, 0, 0, 4'h9);
    add(4,  16'h0020, 0, 4'b1110, 1, 1, 0, 4'h5);
    add(8,  16'h0020, 1, 4'b1110, 0, 1, 0, 4'h5);
    add(16, 16'h0000, 0, 4'b1110, 0, 0, 0, 4'h5);
    add(40, 16'h8001, 0, 4'b1110, 0, 0, 0, 4'h5);
    add(16, 16'h0000, 0, 4'b1110, 0, 0, 0, 4'h5);
    add(16, 16'h0004, 0, 4'b1110, 1, 1, 0, 4'h2);
    add(16, 16'h0000, 0, 4'b1110, 1, 0, 0, 4'h2);
    add(16, 16'h8000, 0, 4'b1110, 1, 1, 1, 4'hF);
    add(0,  16'h8000, 1, 4'b1110, 0, 1, 0, 4'hF);
    add(16, 16'h0000, 0, 4'b1110, 0, 0, 0, 4'hF);
    add(16, 16'h0008, 0, 4'b1110, 1, 1, 0, 4'h3);
    add(0,  16'h0008, 1, 4'b1110, 0, 1, 0, 4'h3);
    add(20, 16'h0048, 0, 4'b1110, 0, 1, 0, 4'h3);
    add(20, 16'h0010, 0, 4'b1110, 0, 1, 0, 4'h3);
    add(16, 16'h0000, 0, 4'b1110, 0, 0, 0, 4'h3);
    add(0,  16'h0000, 1, 4'b1110, 0, 0, 0, 4'h3);

    repeat (3) @(negedge orgclk);
    chk_all("in_reset", 4'b1110, 0, 0, 0, 4'h0);
    reset = 1'b0;
    repeat (2) @(negedge orgclk);
    chk_all("post_reset", 4'b1110, 0, 0, 0, 4'h0);

    foreach (vecs[i]) begin
      keys = vecs[i].keys;
      if (vecs[i].ack) begin
        key_ack = 1'b1;
        @(negedge orgclk);
        key_ack = 1'b0;
      end
      repeat (vecs[i].ticks) do_tick(1'b0);
      chk_all($sformatf("v%0d", i), vecs[i].e_col, vecs[i].e_valid,
              vecs[i].e_down, vecs[i].e_ovr, vecs[i].e_code);
    end

    // Accept and ack landing on the same edge: new key stays valid, no overrun.
    keys = 16'h1000;
    repeat (16) do_tick(1'b0);
    chk_all("pC", 4'b1110, 1, 1, 0, 4'hC);
    keys = 16'h0000;
    repeat (16) do_tick(1'b0);
    chk_all("relC", 4'b1110, 1, 0, 0, 4'hC);
    keys = 16'h0400;
    repeat (15) do_tick(1'b0);
    chk_all("pA_pre", 4'b0111, 1, 0, 0, 4'hC);
    do_tick(1'b1);
    chk_all("pA_ack", 4'b1110, 1, 1, 0, 4'hA);

    // Reset mid-press, then the held key is re-accepted after four full frames.
    do_tick(1'b0);
    chk_all("pre_rst", 4'b1101, 1, 1, 0, 4'hA);
    reset = 1'b1;
    @(negedge orgclk);
    chk_all("mid_rst", 4'b1110, 0, 0, 0, 4'h0);
    repeat (4) @(negedge orgclk);
    reset = 1'b0;
    repeat (12) do_tick(1'b0);
    chk_all("rst_f3", 4'b1110, 0, 0, 0, 4'h0);
    repeat (4) do_tick(1'b0);
    chk_all("rst_f4", 4'b1110, 1, 1, 0, 4'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
